// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Coin-slot front end for the vending machine FSM. It synchronises and
//   debounces the nickel and dime sensor lines and turns each clean rising
//   edge into a coin event. Accepted coins wait in a small circular FIFO.
//   Each queued coin is then presented on coin_code for exactly one cycle,
//   followed by at least GAP_CYCLES idle (00) cycles.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   coin5_raw   asynchronous nickel-slot sensor (high while coin passes)
//   coin10_raw  asynchronous dime-slot sensor (high while coin passes)
//   enable      1 = accept new coins, 0 = return them (reject pulse)
//   err_clr     clears the sticky jam_err flag
//   coin_code   00 none, 01 nickel, 10 dime (11 never driven)
//   reject      one-cycle pulse: coin seen while enable=0
//   overflow    one-cycle pulse: coin seen while queue full, coin dropped
//   jam_err     sticky: both sensors produced an edge in the same cycle
//   fifo_count  number of queued coins
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin5_raw,
    input  logic                          coin10_raw,
    input  logic                          enable,
    input  logic                          err_clr,
    output logic [1:0]                    coin_code,
    output logic                          reject,
    output logic                          overflow,
    output logic                          jam_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Channel index 0 = nickel, 1 = dime.
    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    stable_r;
    logic [1:0]    stable_d_r;
    logic [1:0]    event_r;
    logic [DW-1:0] db_cnt_r [2];

    logic [1:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;

    state_t        state_r;
    logic [GW-1:0] gap_cnt_r;

    logic          jam_s;
    logic          single_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          reject_s;
    logic          overflow_s;
    logic [1:0]    push_code_s;

    assign raw_s = {coin10_raw, coin5_raw};

    // Two-flop synchroniser on both raw sensor lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive synchronised samples disagree with the stable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != stable_r[i]) begin
                    if (db_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        stable_r[i] <= sync2_r[i];
                        db_cnt_r[i] <= {DW{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {DW{1'b0}};
                end
            end
        end
    end

    // Registered rising-edge detect on the debounced levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d_r <= 2'b00;
            event_r    <= 2'b00;
        end else begin
            stable_d_r <= stable_r;
            event_r    <= stable_r & ~stable_d_r;
        end
    end

    // Event arbitration: jam beats everything, then reject, then push/overflow.
    // A full queue still accepts a coin when the emitter pops in the same cycle.
    always_comb begin
        jam_s       = event_r[0] & event_r[1];
        single_s    = event_r[0] ^ event_r[1];
        full_s      = (fifo_count == CW'(FIFO_DEPTH));
        pop_s       = (state_r == ST_IDLE) && (fifo_count != {CW{1'b0}});
        push_s      = 1'b0;
        reject_s    = 1'b0;
        overflow_s  = 1'b0;
        push_code_s = 2'b00;
        if (single_s) begin
            push_code_s = event_r[0] ? 2'b01 : 2'b10;
            if (!enable) begin
                reject_s = 1'b1;
            end else if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                overflow_s = 1'b1;
            end
        end else begin
            push_code_s = 2'b00;
        end
    end

    // Status outputs: one-cycle reject/overflow pulses and sticky jam flag.
    // A new jam wins over a simultaneous err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            reject   <= 1'b0;
            overflow <= 1'b0;
            jam_err  <= 1'b0;
        end else begin
            reject   <= reject_s;
            overflow <= overflow_s;
            if (jam_s) begin
                jam_err <= 1'b1;
            end else if (err_clr) begin
                jam_err <= 1'b0;
            end else begin
                jam_err <= jam_err;
            end
        end
    end

    // Coin queue storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_code_s;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_count <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Emit FSM: one-cycle coin code, then a forced idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            coin_code <= 2'b00;
            gap_cnt_r <= {GW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        coin_code <= fifo_mem_r[rd_ptr_r];
                        state_r   <= ST_EMIT;
                    end else begin
                        coin_code <= 2'b00;
                    end
                end
                ST_EMIT: begin
                    coin_code <= 2'b00;
                    gap_cnt_r <= GW'(GAP_CYCLES - 1);
                    state_r   <= ST_GAP;
                end
                ST_GAP: begin
                    coin_code <= 2'b00;
                    if (gap_cnt_r == {GW{1'b0}}) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                    end
                end
                default: begin
                    coin_code <= 2'b00;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor. A default instance (GAP_CYCLES=1)
// is the main target. A second instance with a very long gap shares the same
// stimulus, so coins pile up in its queue. That second instance exercises
// overflow, enable-drop draining and reset with a partly full queue.
module tb_coin_acceptor;

    logic       clk;
    logic       rst;
    logic       coin5_raw;
    logic       coin10_raw;
    logic       enable;
    logic       err_clr;

    logic [1:0] coin_code;
    logic       reject;
    logic       overflow;
    logic       jam_err;
    logic [2:0] fifo_count;

    logic [1:0] s_coin_code;
    logic       s_reject;
    logic       s_overflow;
    logic       s_jam_err;
    logic [2:0] s_fifo_count;

    int tests_run;
    int tests_failed;

    // Observation tallies, refreshed by step().
    int         cyc;
    int         first_code;
    int         s_first_code;
    int         b2b;
    int         s_b2b;
    int         illegal;
    int         rej_cnt;
    int         ovf_cnt;
    int         s_ovf_cnt;
    int         s_ovf_not_full;
    logic [1:0] prev_code;
    logic [1:0] s_prev_code;
    logic [1:0] codes_q[$];
    logic [1:0] s_codes_q[$];

    logic [1:0] exp_burst [6];
    logic [1:0] got;

    coin_acceptor dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .enable     (enable),
        .err_clr    (err_clr),
        .coin_code  (coin_code),
        .reject     (reject),
        .overflow   (overflow),
        .jam_err    (jam_err),
        .fifo_count (fifo_count)
    );

    coin_acceptor #(
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (100),
        .FIFO_DEPTH      (4)
    ) dut_slow (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .enable     (enable),
        .err_clr    (err_clr),
        .coin_code  (s_coin_code),
        .reject     (s_reject),
        .overflow   (s_overflow),
        .jam_err    (s_jam_err),
        .fifo_count (s_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        cyc            = -1;
        first_code     = -1;
        s_first_code   = -1;
        b2b            = 0;
        s_b2b          = 0;
        illegal        = 0;
        rej_cnt        = 0;
        ovf_cnt        = 0;
        s_ovf_cnt      = 0;
        s_ovf_not_full = 0;
        prev_code      = 2'b00;
        s_prev_code    = 2'b00;
        codes_q.delete();
        s_codes_q.delete();
    endtask

    // Advance one rising edge and sample at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (coin_code != 2'b00) begin
            codes_q.push_back(coin_code);
            if (first_code < 0) first_code = cyc;
            if (prev_code != 2'b00) b2b++;
        end
        if (s_coin_code != 2'b00) begin
            s_codes_q.push_back(s_coin_code);
            if (s_first_code < 0) s_first_code = cyc;
            if (s_prev_code != 2'b00) s_b2b++;
        end
        if (coin_code == 2'b11 || s_coin_code == 2'b11) illegal++;
        if (reject) rej_cnt++;
        if (overflow) ovf_cnt++;
        if (s_overflow) begin
            s_ovf_cnt++;
            if (s_fifo_count != 3'd4) s_ovf_not_full++;
        end
        prev_code   = coin_code;
        s_prev_code = s_coin_code;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        enable     = 1'b1;
        err_clr    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // One clean coin: raw high for hi cycles, then low for lo cycles.
    task automatic coin(input logic dime, input int hi, input int lo);
        if (dime) coin10_raw = 1'b1;
        else      coin5_raw  = 1'b1;
        repeat (hi) step();
        coin10_raw = 1'b0;
        coin5_raw  = 1'b0;
        repeat (lo) step();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        coin5_raw  = 1'b1;
        coin10_raw = 1'b0;
        enable     = 1'b1;
        err_clr    = 1'b0;
        step();
        step();
        tests_run++;
        if (coin_code !== 2'b00) begin tests_failed++; $display("FAIL reset_code: got %b expected 00", coin_code); end
        tests_run++;
        if (reject !== 1'b0) begin tests_failed++; $display("FAIL reset_reject: got %b expected 0", reject); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests_run++;
        if (jam_err !== 1'b0) begin tests_failed++; $display("FAIL reset_jam: got %b expected 0", jam_err); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        coin5_raw = 1'b0;
        rst       = 1'b0;
        step();
    endtask

    task automatic test_latency();
        do_reset();
        clear_obs();
        coin5_raw = 1'b1;
        repeat (20) step();
        coin5_raw = 1'b0;
        repeat (15) step();
        tests_run++;
        if (codes_q.size() !== 1) begin tests_failed++; $display("FAIL lat_count: got %0d coins expected 1", codes_q.size()); end
        got = (codes_q.size() > 0) ? codes_q[0] : 2'b11;
        tests_run++;
        if (got !== 2'b01) begin tests_failed++; $display("FAIL lat_code: got %b expected 01", got); end
        tests_run++;
        if (first_code !== 8) begin tests_failed++; $display("FAIL lat_edge: got edge %0d expected 8", first_code); end
        tests_run++;
        if (s_first_code !== 8) begin tests_failed++; $display("FAIL lat_edge_slow: got edge %0d expected 8", s_first_code); end
        tests_run++;
        if (b2b !== 0) begin tests_failed++; $display("FAIL lat_width: got %0d wide pulses expected 0", b2b); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL lat_drain: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_glitch();
        do_reset();
        clear_obs();
        coin10_raw = 1'b1;
        repeat (2) step();
        coin10_raw = 1'b0;
        repeat (20) step();
        tests_run++;
        if (codes_q.size() !== 0) begin tests_failed++; $display("FAIL glitch_codes: got %0d coins expected 0", codes_q.size()); end
        tests_run++;
        if (rej_cnt + ovf_cnt !== 0) begin tests_failed++; $display("FAIL glitch_flags: got %0d pulses expected 0", rej_cnt + ovf_cnt); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL glitch_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_burst();
        do_reset();
        clear_obs();
        exp_burst = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) coin(exp_burst[i] == 2'b10, 6, 6);
        repeat (480) step();
        tests_run++;
        if (codes_q.size() !== 6) begin tests_failed++; $display("FAIL burst_count: got %0d coins expected 6", codes_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (codes_q.size() > i) ? codes_q[i] : 2'b11;
            tests_run++;
            if (got !== exp_burst[i]) begin tests_failed++; $display("FAIL burst_order[%0d]: got %b expected %b", i, got, exp_burst[i]); end
        end
        tests_run++;
        if (b2b !== 0) begin tests_failed++; $display("FAIL burst_gap: got %0d adjacent codes expected 0", b2b); end
        tests_run++;
        if (ovf_cnt !== 0) begin tests_failed++; $display("FAIL burst_ovf: got %0d pulses expected 0", ovf_cnt); end
        tests_run++;
        if (s_ovf_cnt !== 1) begin tests_failed++; $display("FAIL slow_ovf: got %0d pulses expected 1", s_ovf_cnt); end
        tests_run++;
        if (s_ovf_not_full !== 0) begin tests_failed++; $display("FAIL slow_ovf_full: got %0d pulses at count!=4 expected 0", s_ovf_not_full); end
        tests_run++;
        if (s_codes_q.size() !== 5) begin tests_failed++; $display("FAIL slow_count: got %0d coins expected 5", s_codes_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (s_codes_q.size() > i) ? s_codes_q[i] : 2'b11;
            tests_run++;
            if (got !== exp_burst[i]) begin tests_failed++; $display("FAIL slow_order[%0d]: got %b expected %b", i, got, exp_burst[i]); end
        end
        tests_run++;
        if (s_b2b !== 0) begin tests_failed++; $display("FAIL slow_gap: got %0d adjacent codes expected 0", s_b2b); end
        tests_run++;
        if (illegal !== 0) begin tests_failed++; $display("FAIL code_11: got %0d illegal codes expected 0", illegal); end
    endtask

    task automatic test_jam();
        do_reset();
        clear_obs();
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        repeat (6) step();
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        repeat (10) step();
        tests_run++;
        if (jam_err !== 1'b1) begin tests_failed++; $display("FAIL jam_set: got %b expected 1", jam_err); end
        tests_run++;
        if (codes_q.size() !== 0) begin tests_failed++; $display("FAIL jam_codes: got %0d coins expected 0", codes_q.size()); end
        tests_run++;
        if (rej_cnt + ovf_cnt !== 0) begin tests_failed++; $display("FAIL jam_flags: got %0d pulses expected 0", rej_cnt + ovf_cnt); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL jam_count: got %0d expected 0", fifo_count); end
        coin(1'b0, 6, 10);
        got = (codes_q.size() == 1) ? codes_q[0] : 2'b11;
        tests_run++;
        if (got !== 2'b01) begin tests_failed++; $display("FAIL jam_next_coin: got %b (%0d coins) expected single 01", got, codes_q.size()); end
        tests_run++;
        if (jam_err !== 1'b1) begin tests_failed++; $display("FAIL jam_sticky: got %b expected 1", jam_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tests_run++;
        if (jam_err !== 1'b0) begin tests_failed++; $display("FAIL jam_clear: got %b expected 0", jam_err); end
    endtask

    task automatic test_enable();
        do_reset();
        clear_obs();
        enable = 1'b0;
        coin(1'b1, 6, 10);
        tests_run++;
        if (rej_cnt !== 1) begin tests_failed++; $display("FAIL rej_pulse: got %0d pulses expected 1", rej_cnt); end
        tests_run++;
        if (codes_q.size() !== 0) begin tests_failed++; $display("FAIL rej_codes: got %0d coins expected 0", codes_q.size()); end
        tests_run++;
        if (fifo_count !== 3'd0) begin tests_failed++; $display("FAIL rej_count: got %0d expected 0", fifo_count); end
        clear_obs();
        enable = 1'b1;
        coin(1'b0, 6, 6);
        coin(1'b1, 6, 6);
        enable = 1'b0;
        tests_run++;
        if (s_fifo_count !== 3'd1) begin tests_failed++; $display("FAIL drain_queued: got %0d expected 1", s_fifo_count); end
        repeat (250) step();
        got = (codes_q.size() == 2) ? codes_q[1] : 2'b11;
        tests_run++;
        if (codes_q.size() !== 2 || codes_q[0] !== 2'b01 || got !== 2'b10) begin
            tests_failed++; $display("FAIL drain_main: got %0d coins expected 01,10", codes_q.size());
        end
        got = (s_codes_q.size() == 2) ? s_codes_q[1] : 2'b11;
        tests_run++;
        if (s_codes_q.size() !== 2 || s_codes_q[0] !== 2'b01 || got !== 2'b10) begin
            tests_failed++; $display("FAIL drain_slow: got %0d coins expected 01,10", s_codes_q.size());
        end
        tests_run++;
        if (rej_cnt !== 0) begin tests_failed++; $display("FAIL drain_reject: got %0d pulses expected 0", rej_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_obs();
        for (int i = 0; i < 5; i++) coin(i[0], 6, 6);
        for (int k = 0; k < 400 && s_codes_q.size() < 2; k++) step();
        tests_run++;
        if (s_codes_q.size() !== 2) begin tests_failed++; $display("FAIL mid_timeout: got %0d coins expected 2", s_codes_q.size()); end
        tests_run++;
        if (s_fifo_count !== 3'd3) begin tests_failed++; $display("FAIL mid_count: got %0d expected 3", s_fifo_count); end
        rst = 1'b1;
        step();
        tests_run++;
        if (s_coin_code !== 2'b00) begin tests_failed++; $display("FAIL mid_code: got %b expected 00", s_coin_code); end
        tests_run++;
        if (s_fifo_count !== 3'd0) begin tests_failed++; $display("FAIL mid_flush: got %0d expected 0", s_fifo_count); end
        rst = 1'b0;
        clear_obs();
        repeat (300) step();
        tests_run++;
        if (s_codes_q.size() + codes_q.size() !== 0) begin
            tests_failed++; $display("FAIL mid_after: got %0d coins expected 0", s_codes_q.size() + codes_q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_obs();
        test_reset();
        test_latency();
        test_glitch();
        test_burst();
        test_jam();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
